router_fsm: RTL and testbench
=============================

Name: router_fsm

Overview:
Write-side controller for the 1x3 router. It decodes the destination address from the header byte and steps the packet through header, payload and parity loading. It steers write enables to one of three router_fifo instances and stalls the source (busy) while the target FIFO is full or still draining. It also generates per-FIFO soft_reset when a destination stops reading.

Parameters:
TIMEOUT, 30, idle read cycles with non-empty FIFO before soft_reset fires
CNT_W, 5, timer width; must satisfy 2**CNT_W >= TIMEOUT

Ports:
clock  in  1  system clock, all logic on rising edge
resetn  in  1  synchronous, active-low reset
pkt_valid  in  1  source drives header/payload bytes; falls with parity byte
data_in  in  2  header bits [1:0] = destination address (0,1,2 valid; 3 invalid)
fifo_full  in  3  full flag per FIFO
fifo_empty  in  3  empty flag per FIFO
read_enb  in  3  read enable per FIFO (from destinations)
parity_done  in  1  register block: parity byte captured
low_pkt_valid  in  1  register block: pkt_valid fell while FIFO full
write_enb  out  3  one-hot FIFO write enable
write_enb_reg  out  1  register block load enable
detect_add  out  1  in DECODE_ADDRESS
lfd_state  out  1  in LOAD_FIRST_DATA
ld_state  out  1  in LOAD_DATA
laf_state  out  1  in LOAD_AFTER_FULL
full_state  out  1  in FIFO_FULL_STATE
rst_int_reg  out  1  in CHECK_PARITY_ERROR
busy  out  1  source must hold data
soft_reset  out  3  per-FIFO soft reset pulse, registered

Behaviour:
- Reset: synchronous on resetn=0 at a clock edge. Values: state=DECODE_ADDRESS, addr_reg=0, timers=0, soft_reset=0.
- Reset output values follow from the state: detect_add=1; all other state flags, busy, write_enb_reg and write_enb = 0.
- State flags and busy are Moore decodes of the state register, zero latency.
- write_enb[i] = write_enb_reg && addr_reg==i. Never more than one bit set.
- addr_reg loads data_in in DECODE_ADDRESS when pkt_valid && data_in!=3. It holds otherwise.
- sel_full = fifo_full[addr_reg]; sel_empty = fifo_empty[addr_reg].
- DECODE_ADDRESS: busy=0.
  - pkt_valid, addr valid, fifo_empty[data_in] -> LOAD_FIRST_DATA.
  - pkt_valid, addr valid, FIFO not empty -> WAIT_TILL_EMPTY.
  - data_in==3 or !pkt_valid -> stay. An invalid-address packet is dropped: no write ever issued.
- LOAD_FIRST_DATA: busy=1, write_enb_reg=0 -> LOAD_DATA unconditionally.
- LOAD_DATA: busy=0, write_enb_reg=1.
  - sel_full -> FIFO_FULL_STATE.
  - else !pkt_valid -> LOAD_PARITY.
  - else stay.
  - sel_full has priority when pkt_valid falls in the same cycle.
- FIFO_FULL_STATE: busy=1, write_enb_reg=0. !sel_full -> LOAD_AFTER_FULL, else stay.
- LOAD_AFTER_FULL: busy=1, write_enb_reg=1.
  - parity_done -> DECODE_ADDRESS.
  - else low_pkt_valid -> LOAD_PARITY.
  - else -> LOAD_DATA.
- LOAD_PARITY: busy=1, write_enb_reg=1 -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: busy=1. sel_full -> FIFO_FULL_STATE, else DECODE_ADDRESS.
- WAIT_TILL_EMPTY: busy=1, write_enb_reg=0. sel_empty -> LOAD_FIRST_DATA, else stay.
- Soft-reset abort: soft_reset[addr_reg]=1 in any state other than DECODE_ADDRESS forces next state DECODE_ADDRESS. This overrides all other transitions. Other FIFOs' soft_reset do not affect the state.
- Encoding: 3-bit binary. Unused codes go to DECODE_ADDRESS next cycle.

Optional Feature:
Macro ROUTER_SOFT_RESET_TIMER_EN.
- Defined: each FIFO i has timer[i] (CNT_W bits).
  - Cleared when fifo_empty[i] or read_enb[i].
  - Otherwise increments each cycle.
  - When timer[i]==TIMEOUT-1 and it would increment: soft_reset[i]<=1 for exactly one cycle and timer[i]<=0.
  - soft_reset=1 exactly TIMEOUT cycles after the last read of a non-empty FIFO.
- Undefined: no timers are synthesized, soft_reset is tied to 3'b000, and the abort transition never occurs.

Test Plan:
- Reset, all FIFOs empty; header 0x15 (len 5, addr 1) with pkt_valid -> LOAD_FIRST_DATA next cycle. Then LOAD_DATA, write_enb=3'b010 for 5 payload cycles; pkt_valid low -> LOAD_PARITY -> CHECK_PARITY_ERROR -> DECODE_ADDRESS; busy=0 only in DECODE_ADDRESS/LOAD_DATA.
- Header addr 2 with fifo_empty[2]=0 -> WAIT_TILL_EMPTY, busy=1, write_enb=0. Set fifo_empty[2]=1 -> LOAD_FIRST_DATA next cycle.
- fifo_full[0] asserts in LOAD_DATA -> FIFO_FULL_STATE, write_enb=0. Deassert with low_pkt_valid=1, parity_done=0 -> LOAD_AFTER_FULL then LOAD_PARITY. Repeat with parity_done=1 -> LOAD_AFTER_FULL then DECODE_ADDRESS.
- Header data_in=3 with pkt_valid held 4 cycles -> state stays DECODE_ADDRESS, write_enb stays 000, addr_reg unchanged.
- Macro defined: fifo_empty[1]=0, read_enb[1]=0 for 30 cycles -> soft_reset[1]=1 on the 30th edge for exactly 1 cycle. A read at cycle 29 restarts the count. If addr_reg=1 mid-packet -> DECODE_ADDRESS next cycle.
- resetn low during LOAD_DATA -> next edge: detect_add=1, write_enb=000, busy=0, soft_reset=000.

Source files
------------

// File: rtl/router_fsm.sv
// router_fsm: write-side controller of the 1x3 router (address decode, load sequencing, busy, FIFO steering).
// Build option ROUTER_SOFT_RESET_TIMER_EN adds per-FIFO read-timeout soft_reset; otherwise soft_reset is 0.
module router_fsm #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic [2:0] write_enb,
    output logic       write_enb_reg,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       busy,
    output logic [2:0] soft_reset
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_e;

    state_e     state_q;
    logic [1:0] addr_reg_q;
    logic       sel_full;
    logic       sel_empty;
    logic       dest_empty;
    logic       abort;

    // Zero-padded to four entries so a 2-bit index can never fall outside the vector.
    logic [3:0] full_ext;
    logic [3:0] empty_ext;
    logic [3:0] sr_ext;

    assign full_ext   = {1'b0, fifo_full};
    assign empty_ext  = {1'b0, fifo_empty};
    assign sr_ext     = {1'b0, soft_reset};

    assign sel_full   = full_ext[addr_reg_q];
    assign sel_empty  = empty_ext[addr_reg_q];
    assign dest_empty = empty_ext[data_in];
    assign abort      = (state_q != DECODE_ADDRESS) && sr_ext[addr_reg_q];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= DECODE_ADDRESS;
            addr_reg_q <= 2'd0;
        end else if (abort) begin
            state_q <= DECODE_ADDRESS;
        end else begin
            case (state_q)
                DECODE_ADDRESS: begin
                    if (pkt_valid && data_in != 2'd3) begin
                        addr_reg_q <= data_in;
                        state_q    <= dest_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
                LOAD_FIRST_DATA: state_q <= LOAD_DATA;
                LOAD_DATA: begin
                    if (sel_full)
                        state_q <= FIFO_FULL_STATE;
                    else if (!pkt_valid)
                        state_q <= LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!sel_full)
                        state_q <= LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done)
                        state_q <= DECODE_ADDRESS;
                    else if (low_pkt_valid)
                        state_q <= LOAD_PARITY;
                    else
                        state_q <= LOAD_DATA;
                end
                LOAD_PARITY:        state_q <= CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: state_q <= sel_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                WAIT_TILL_EMPTY: begin
                    if (sel_empty)
                        state_q <= LOAD_FIRST_DATA;
                end
                default:            state_q <= DECODE_ADDRESS;
            endcase
        end
    end

    assign detect_add    = (state_q == DECODE_ADDRESS);
    assign lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign ld_state      = (state_q == LOAD_DATA);
    assign laf_state     = (state_q == LOAD_AFTER_FULL);
    assign full_state    = (state_q == FIFO_FULL_STATE);
    assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
    assign write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_AFTER_FULL) ||
                           (state_q == LOAD_PARITY);

    // NOTE: default first so every path through the block assigns write_enb; no latch is inferred.
    always_comb begin
        write_enb = 3'b000;
        for (int i = 0; i < 3; i++)
            write_enb[i] = write_enb_reg && (addr_reg_q == 2'(i));
    end

`ifdef ROUTER_SOFT_RESET_TIMER_EN
    logic [CNT_W-1:0] timer_q [3];

    // A FIFO holding data that nobody reads for TIMEOUT cycles gets a one-cycle flush pulse.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < 3; i++)
                timer_q[i] <= '0;
            soft_reset <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (fifo_empty[i] || read_enb[i]) begin
                    timer_q[i]    <= '0;
                    soft_reset[i] <= 1'b0;
                end else if (timer_q[i] == CNT_W'(TIMEOUT - 1)) begin
                    timer_q[i]    <= '0;
                    soft_reset[i] <= 1'b1;
                end else begin
                    timer_q[i]    <= timer_q[i] + CNT_W'(1);
                    soft_reset[i] <= 1'b0;
                end
            end
        end
    end
`else
    logic unused_timer;

    assign soft_reset   = 3'b000;
    assign unused_timer = ^{read_enb, CNT_W'(TIMEOUT)};
`endif

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: directed scenarios plus randomized traffic against a behavioural model.
// Soft-reset timer scenarios are exercised when ROUTER_SOFT_RESET_TIMER_EN is defined.
module tb_router_fsm;

    localparam int TIMEOUT = 30;

    typedef enum logic [2:0] {
        P_DECODE, P_FIRST, P_LOAD, P_FULL, P_AFTER_FULL, P_PARITY, P_CHECK, P_WAIT
    } phase_e;

    typedef struct {
        logic       pv;
        logic [1:0] di;
        logic [2:0] fe;
        logic [2:0] ff;
        logic       lpv;
        logic       pd;
        phase_e     want;
    } step_t;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] read_enb;
    logic       parity_done;
    logic       low_pkt_valid;
    logic [2:0] write_enb;
    logic       write_enb_reg;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic       busy;
    logic [2:0] soft_reset;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    router_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .read_enb      (read_enb),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .write_enb     (write_enb),
        .write_enb_reg (write_enb_reg),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy),
        .soft_reset    (soft_reset)
    );

    // {detect_add, lfd, ld, laf, full, rst_int, busy, write_enb_reg, write_enb[2:0]}
    logic [10:0] obs;
    assign obs = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy,
                  write_enb_reg, write_enb};

    function automatic logic [10:0] expect_vec(input phase_e p, input logic [1:0] a);
        logic [2:0] oh;
        oh = 3'b001 << a;
        case (p)
            P_DECODE:     return {7'b1000000, 1'b0, 3'b000};
            P_FIRST:      return {7'b0100001, 1'b0, 3'b000};
            P_LOAD:       return {7'b0010000, 1'b1, oh};
            P_AFTER_FULL: return {7'b0001001, 1'b1, oh};
            P_FULL:       return {7'b0000101, 1'b0, 3'b000};
            P_CHECK:      return {7'b0000011, 1'b0, 3'b000};
            P_PARITY:     return {7'b0000001, 1'b1, oh};
            P_WAIT:       return {7'b0000001, 1'b0, 3'b000};
            default:      return 11'h7ff;
        endcase
    endfunction

    function automatic step_t s(input logic pv, input logic [1:0] di, input logic [2:0] fe,
                                input logic [2:0] ff, input logic lpv, input logic pd,
                                input phase_e want);
        step_t r;
        r.pv = pv; r.di = di; r.fe = fe; r.ff = ff; r.lpv = lpv; r.pd = pd; r.want = want;
        return r;
    endfunction

    task automatic apply(input step_t st);
        pkt_valid     = st.pv;
        data_in       = st.di;
        fifo_empty    = st.fe;
        fifo_full     = st.ff;
        read_enb      = 3'b111;
        low_pkt_valid = st.lpv;
        parity_done   = st.pd;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; pkt_valid = 1'b1; data_in = 2'd1; fifo_empty = 3'b000;
        fifo_full = 3'b111; read_enb = 3'b000; low_pkt_valid = 1'b1; parity_done = 1'b1;
        tick(); tick();
        n_vec++;
        if (obs !== expect_vec(P_DECODE, 2'd0) || soft_reset !== 3'b000) begin
            n_err++;
            $display("FAIL reset: got %b sr=%b want %b sr=000", obs, soft_reset, expect_vec(P_DECODE, 2'd0));
        end
        resetn = 1'b1;
        apply(s(1'b0, 2'd0, 3'b111, 3'b000, 1'b0, 1'b0, P_DECODE));
        tick();
        n_vec++;
        if (obs !== expect_vec(P_DECODE, 2'd0)) begin
            n_err++;
            $display("FAIL reset_release: got %b want %b", obs, expect_vec(P_DECODE, 2'd0));
        end
    endtask

    task automatic test_packet();
        step_t tbl[$];
        logic [10:0] exp;
        tbl = '{s(1, 2'd1, 3'b111, 3'b000, 0, 0, P_FIRST),
                s(1, 2'd0, 3'b111, 3'b000, 0, 0, P_LOAD),
                s(1, 2'd3, 3'b111, 3'b000, 0, 0, P_LOAD),
                s(1, 2'd2, 3'b111, 3'b000, 0, 0, P_LOAD),
                s(1, 2'd1, 3'b111, 3'b000, 0, 0, P_LOAD),
                s(1, 2'd0, 3'b111, 3'b000, 0, 0, P_LOAD),
                s(0, 2'd0, 3'b111, 3'b000, 0, 0, P_PARITY),
                s(0, 2'd0, 3'b111, 3'b000, 0, 0, P_CHECK),
                s(0, 2'd0, 3'b111, 3'b000, 0, 0, P_DECODE),
                s(0, 2'd2, 3'b111, 3'b000, 0, 0, P_DECODE)};
        foreach (tbl[i]) begin
            apply(tbl[i]);
            tick();
            exp = expect_vec(tbl[i].want, 2'd1);
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL packet step %0d: got %b want %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_wait_empty();
        step_t tbl[$];
        logic [10:0] exp;
        tbl = '{s(1, 2'd2, 3'b011, 3'b000, 0, 0, P_WAIT),
                s(1, 2'd0, 3'b011, 3'b000, 0, 0, P_WAIT),
                s(1, 2'd1, 3'b011, 3'b000, 0, 0, P_WAIT),
                s(1, 2'd0, 3'b111, 3'b000, 0, 0, P_FIRST),
                s(1, 2'd0, 3'b111, 3'b000, 0, 0, P_LOAD),
                s(0, 2'd0, 3'b111, 3'b000, 0, 0, P_PARITY),
                s(0, 2'd0, 3'b111, 3'b000, 0, 0, P_CHECK),
                s(0, 2'd0, 3'b111, 3'b000, 0, 0, P_DECODE)};
        foreach (tbl[i]) begin
            apply(tbl[i]);
            tick();
            exp = expect_vec(tbl[i].want, 2'd2);
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL wait_empty step %0d: got %b want %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_full();
        step_t tbl[$];
        logic [10:0] exp;
        tbl = '{s(1, 2'd0, 3'b111, 3'b000, 0, 0, P_FIRST),
                s(1, 2'd0, 3'b111, 3'b000, 0, 0, P_LOAD),
                s(1, 2'd0, 3'b111, 3'b110, 0, 0, P_LOAD),
                s(1, 2'd0, 3'b111, 3'b001, 0, 0, P_FULL),
                s(1, 2'd0, 3'b111, 3'b001, 0, 0, P_FULL),
                s(0, 2'd0, 3'b111, 3'b000, 1, 0, P_AFTER_FULL),
                s(0, 2'd0, 3'b111, 3'b000, 1, 0, P_PARITY),
                s(0, 2'd0, 3'b111, 3'b000, 0, 0, P_CHECK),
                s(0, 2'd0, 3'b111, 3'b000, 0, 0, P_DECODE),
                s(1, 2'd0, 3'b111, 3'b000, 0, 0, P_FIRST),
                s(1, 2'd0, 3'b111, 3'b000, 0, 0, P_LOAD),
                s(0, 2'd0, 3'b111, 3'b001, 0, 0, P_FULL),
                s(0, 2'd0, 3'b111, 3'b000, 1, 1, P_AFTER_FULL),
                s(0, 2'd0, 3'b111, 3'b000, 1, 1, P_DECODE),
                s(1, 2'd0, 3'b111, 3'b000, 0, 0, P_FIRST),
                s(1, 2'd0, 3'b111, 3'b000, 0, 0, P_LOAD),
                s(0, 2'd0, 3'b111, 3'b000, 0, 0, P_PARITY),
                s(0, 2'd0, 3'b111, 3'b001, 0, 0, P_CHECK),
                s(0, 2'd0, 3'b111, 3'b001, 0, 0, P_FULL),
                s(0, 2'd0, 3'b111, 3'b000, 0, 0, P_AFTER_FULL),
                s(0, 2'd0, 3'b111, 3'b000, 0, 0, P_LOAD),
                s(0, 2'd0, 3'b111, 3'b000, 0, 0, P_PARITY),
                s(0, 2'd0, 3'b111, 3'b000, 0, 0, P_CHECK),
                s(0, 2'd0, 3'b111, 3'b000, 0, 0, P_DECODE)};
        foreach (tbl[i]) begin
            apply(tbl[i]);
            tick();
            exp = expect_vec(tbl[i].want, 2'd0);
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL full step %0d: got %b want %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_invalid_addr();
        step_t tbl[$];
        logic [10:0] exp;
        tbl = '{s(1, 2'd3, 3'b111, 3'b000, 0, 0, P_DECODE),
                s(1, 2'd3, 3'b111, 3'b000, 0, 0, P_DECODE),
                s(1, 2'd3, 3'b111, 3'b000, 0, 0, P_DECODE),
                s(1, 2'd3, 3'b111, 3'b000, 0, 0, P_DECODE),
                s(1, 2'd1, 3'b111, 3'b000, 0, 0, P_FIRST),
                s(1, 2'd3, 3'b111, 3'b000, 0, 0, P_LOAD),
                s(0, 2'd3, 3'b111, 3'b000, 0, 0, P_PARITY),
                s(0, 2'd3, 3'b111, 3'b000, 0, 0, P_CHECK),
                s(0, 2'd3, 3'b111, 3'b000, 0, 0, P_DECODE)};
        foreach (tbl[i]) begin
            apply(tbl[i]);
            tick();
            exp = expect_vec(tbl[i].want, 2'd1);
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL invalid_addr step %0d: got %b want %b", i, obs, exp);
            end
        end
    endtask

`ifdef ROUTER_SOFT_RESET_TIMER_EN
    task automatic test_soft_reset();
        logic [2:0]  want_sr;
        logic [10:0] exp;
        phase_e      tail [3] = '{P_PARITY, P_CHECK, P_DECODE};

        resetn = 1'b0;
        apply(s(0, 2'd0, 3'b111, 3'b000, 0, 0, P_DECODE));
        tick();
        resetn = 1'b1;

        // Starved FIFO 1: pulse on the 30th edge, then the count restarts.
        fifo_empty = 3'b101; read_enb = 3'b000;
        for (int k = 1; k <= 31; k++) begin
            tick();
            want_sr = (k == 30) ? 3'b010 : 3'b000;
            n_vec++;
            if (soft_reset !== want_sr) begin
                n_err++;
                $display("FAIL sr_timeout edge %0d: got %b want %b", k, soft_reset, want_sr);
            end
        end

        // Read on the 29th idle cycle suppresses the pulse and restarts the count.
        for (int k = 1; k <= 29; k++) begin
            read_enb = (k == 29) ? 3'b010 : 3'b000;
            tick();
            n_vec++;
            if (soft_reset !== 3'b000) begin
                n_err++;
                $display("FAIL sr_read_restart edge %0d: got %b want 000", k, soft_reset);
            end
        end
        read_enb = 3'b000;
        for (int k = 1; k <= 30; k++) begin
            tick();
            want_sr = (k == 30) ? 3'b010 : 3'b000;
            n_vec++;
            if (soft_reset !== want_sr) begin
                n_err++;
                $display("FAIL sr_after_read edge %0d: got %b want %b", k, soft_reset, want_sr);
            end
        end

        // Abort of an in-flight packet to FIFO 1.
        pkt_valid = 1'b1; data_in = 2'd1; fifo_empty = 3'b111;
        tick();
        n_vec++;
        if (obs !== expect_vec(P_FIRST, 2'd1) || soft_reset !== 3'b000) begin
            n_err++;
            $display("FAIL abort_header: got %b sr=%b want %b sr=000", obs, soft_reset, expect_vec(P_FIRST, 2'd1));
        end
        fifo_empty = 3'b101;
        for (int k = 1; k <= 30; k++) begin
            tick();
            want_sr = (k == 30) ? 3'b010 : 3'b000;
            exp = expect_vec(P_LOAD, 2'd1);
            n_vec++;
            if (obs !== exp || soft_reset !== want_sr) begin
                n_err++;
                $display("FAIL abort_load edge %0d: got %b sr=%b want %b sr=%b", k, obs, soft_reset, exp, want_sr);
            end
        end
        tick();
        n_vec++;
        if (obs !== expect_vec(P_DECODE, 2'd0)) begin
            n_err++;
            $display("FAIL abort_taken: got %b want %b", obs, expect_vec(P_DECODE, 2'd0));
        end
        pkt_valid = 1'b0; fifo_empty = 3'b111;
        tick();

        // Another FIFO's pulse must not disturb a packet to FIFO 0.
        pkt_valid = 1'b1; data_in = 2'd0;
        tick();
        fifo_empty = 3'b011;
        for (int k = 1; k <= 32; k++) begin
            tick();
            want_sr = (k == 30) ? 3'b100 : 3'b000;
            exp = expect_vec(P_LOAD, 2'd0);
            n_vec++;
            if (obs !== exp || soft_reset !== want_sr) begin
                n_err++;
                $display("FAIL other_fifo edge %0d: got %b sr=%b want %b sr=%b", k, obs, soft_reset, exp, want_sr);
            end
        end
        pkt_valid = 1'b0; fifo_empty = 3'b111; read_enb = 3'b111;
        foreach (tail[i]) begin
            tick();
            exp = expect_vec(tail[i], 2'd0);
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL other_fifo_tail %0d: got %b want %b", i, obs, exp);
            end
        end
    endtask
`else
    task automatic test_soft_reset();
        pkt_valid = 1'b0; fifo_empty = 3'b000; read_enb = 3'b000;
        for (int k = 1; k <= 40; k++) begin
            tick();
            n_vec++;
            if (soft_reset !== 3'b000 || obs !== expect_vec(P_DECODE, 2'd0)) begin
                n_err++;
                $display("FAIL sr_disabled edge %0d: got %b sr=%b want %b sr=000", k, obs, soft_reset, expect_vec(P_DECODE, 2'd0));
            end
        end
        fifo_empty = 3'b111; read_enb = 3'b111;
    endtask
`endif

    task automatic test_reset_mid();
        apply(s(1, 2'd2, 3'b111, 3'b000, 0, 0, P_FIRST));
        tick();
        tick();
        n_vec++;
        if (obs !== expect_vec(P_LOAD, 2'd2)) begin
            n_err++;
            $display("FAIL reset_mid_load: got %b want %b", obs, expect_vec(P_LOAD, 2'd2));
        end
        resetn = 1'b0;
        tick();
        n_vec++;
        if (obs !== expect_vec(P_DECODE, 2'd0) || soft_reset !== 3'b000) begin
            n_err++;
            $display("FAIL reset_mid: got %b sr=%b want %b sr=000", obs, soft_reset, expect_vec(P_DECODE, 2'd0));
        end
        resetn = 1'b1; pkt_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        phase_e      m_ph, n_ph;
        logic [1:0]  m_addr, n_addr;
        logic [2:0]  m_sr, n_sr, sel;
        logic        sel_full, sel_empty, starve;
        logic [10:0] exp;
`ifdef ROUTER_SOFT_RESET_TIMER_EN
        int          m_idle [3];
`endif
        resetn = 1'b0;
        apply(s(0, 2'd0, 3'b111, 3'b000, 0, 0, P_DECODE));
        tick();
        resetn = 1'b1;
        m_ph = P_DECODE; m_addr = 2'd0; m_sr = 3'b000;
`ifdef ROUTER_SOFT_RESET_TIMER_EN
        m_idle = '{0, 0, 0};
`endif
        for (int i = 0; i < 3000; i++) begin
            starve        = ((i / 150) % 3) == 2;
            pkt_valid     = $urandom_range(0, 3) != 0;
            data_in       = 2'($urandom);
            fifo_empty    = starve ? 3'b000 : 3'($urandom | $urandom);
            fifo_full     = 3'($urandom & $urandom & $urandom);
            read_enb      = starve ? 3'b000 : 3'($urandom);
            low_pkt_valid = $urandom_range(0, 3) == 0;
            parity_done   = $urandom_range(0, 3) == 0;
            resetn        = $urandom_range(0, 199) != 0;

            sel       = 3'b001 << m_addr;
            sel_full  = |(fifo_full & sel);
            sel_empty = |(fifo_empty & sel);
            n_ph = m_ph; n_addr = m_addr; n_sr = 3'b000;
            if (!resetn) begin
                n_ph = P_DECODE; n_addr = 2'd0;
`ifdef ROUTER_SOFT_RESET_TIMER_EN
                m_idle = '{0, 0, 0};
`endif
            end else begin
                if (m_ph != P_DECODE && |(m_sr & sel)) begin
                    n_ph = P_DECODE;
                end else begin
                    case (m_ph)
                        P_DECODE: if (pkt_valid && data_in != 2'd3) begin
                            n_addr = data_in;
                            n_ph   = |(fifo_empty & (3'b001 << data_in)) ? P_FIRST : P_WAIT;
                        end
                        P_FIRST:      n_ph = P_LOAD;
                        P_LOAD:       n_ph = sel_full ? P_FULL : (!pkt_valid ? P_PARITY : P_LOAD);
                        P_FULL:       n_ph = sel_full ? P_FULL : P_AFTER_FULL;
                        P_AFTER_FULL: n_ph = parity_done ? P_DECODE : (low_pkt_valid ? P_PARITY : P_LOAD);
                        P_PARITY:     n_ph = P_CHECK;
                        P_CHECK:      n_ph = sel_full ? P_FULL : P_DECODE;
                        P_WAIT:       n_ph = sel_empty ? P_FIRST : P_WAIT;
                        default:      n_ph = P_DECODE;
                    endcase
                end
`ifdef ROUTER_SOFT_RESET_TIMER_EN
                // Idle-cycle count per FIFO; a pulse when it reaches TIMEOUT.
                for (int f = 0; f < 3; f++) begin
                    if (fifo_empty[f] || read_enb[f])
                        m_idle[f] = 0;
                    else
                        m_idle[f]++;
                    n_sr[f] = (m_idle[f] == TIMEOUT);
                    if (n_sr[f])
                        m_idle[f] = 0;
                end
`endif
            end
            tick();
            m_ph = n_ph; m_addr = n_addr; m_sr = n_sr;
            exp = expect_vec(m_ph, m_addr);
            n_vec++;
            if (obs !== exp || soft_reset !== m_sr) begin
                n_err++;
                $display("FAIL random cycle %0d: got %b sr=%b want %b sr=%b", i, obs, soft_reset, exp, m_sr);
            end
        end
        resetn = 1'b1;
        apply(s(0, 2'd0, 3'b111, 3'b000, 0, 0, P_DECODE));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        apply(s(0, 2'd0, 3'b111, 3'b000, 0, 0, P_DECODE));
        test_reset();
        test_packet();
        test_wait_empty();
        test_full();
        test_invalid_addr();
        test_soft_reset();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
